// File: rtl/csr_issue_buffer.sv
// In-order issue buffer for CSR ops: holds dispatched ops until rs1 is known and
// the op reaches the ROB head, then issues the head as a single registered pulse.
module csr_issue_buffer #(
  parameter int DEPTH   = 4,
  parameter int ROB_LEN = 16,
  localparam int IW     = $clog2(ROB_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_valid,
  output logic          disp_ready,
  input  logic [2:0]    disp_funct3,
  input  logic [4:0]    disp_uimm,
  input  logic [31:0]   disp_imm,
  input  logic [31:0]   disp_pc,
  input  logic [IW-1:0] disp_rob_idx,
  input  logic [6:0]    disp_rd,
  input  logic [6:0]    disp_rs1_tag,
  input  logic          disp_rs1_rdy,
  input  logic [31:0]   disp_rs1_data,
  input  logic          wb_valid,
  input  logic [6:0]    wb_rd,
  input  logic [31:0]   wb_data,
  input  logic [IW-1:0] rob_head_idx,
  input  logic          flush,
  output logic          csr_i_valid,
  output logic [2:0]    csr_i_funct3,
  output logic [4:0]    csr_i_uimm,
  output logic [31:0]   csr_i_imm,
  output logic [31:0]   csr_i_rs1_data,
  output logic [31:0]   csr_i_pc,
  output logic [IW-1:0] csr_i_rob_idx,
  output logic [6:0]    csr_i_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic          e_valid  [DEPTH];
  logic          e_rdy    [DEPTH];
  logic [2:0]    e_funct3 [DEPTH];
  logic [4:0]    e_uimm   [DEPTH];
  logic [31:0]   e_imm    [DEPTH];
  logic [31:0]   e_pc     [DEPTH];
  logic [IW-1:0] e_rob    [DEPTH];
  logic [6:0]    e_rd     [DEPTH];
  logic [6:0]    e_tag    [DEPTH];
  logic [31:0]   e_data   [DEPTH];

  logic        push, pop, push_rdy;
  logic [31:0] push_data;

  // Eligibility uses the registered ready bit, so a same-cycle wakeup issues a cycle later.
  always_comb begin
    disp_ready = !rst && (count < FULL) && !flush;
    push       = disp_valid && disp_ready;
    pop        = (count != '0) && e_rdy[head] && (e_rob[head] == rob_head_idx) && !flush;
    push_rdy   = disp_rs1_rdy || (wb_valid && (wb_rd == disp_rs1_tag));
    push_data  = disp_rs1_rdy ? disp_rs1_data : wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      csr_i_valid    <= 1'b0;
      csr_i_funct3   <= '0;
      csr_i_uimm     <= '0;
      csr_i_imm      <= '0;
      csr_i_rs1_data <= '0;
      csr_i_pc       <= '0;
      csr_i_rob_idx  <= '0;
      csr_i_rd       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_valid[i] <= 1'b0;
        e_rdy[i]   <= 1'b0;
      end
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      csr_i_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_valid[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && !e_rdy[i] && wb_valid && (e_tag[i] == wb_rd)) begin
          e_rdy[i]  <= 1'b1;
          e_data[i] <= wb_data;
        end
      end

      csr_i_valid <= pop;
      if (pop) begin
        e_valid[head]  <= 1'b0;
        csr_i_funct3   <= e_funct3[head];
        csr_i_uimm     <= e_uimm[head];
        csr_i_imm      <= e_imm[head];
        csr_i_rs1_data <= e_data[head];
        csr_i_pc       <= e_pc[head];
        csr_i_rob_idx  <= e_rob[head];
        csr_i_rd       <= e_rd[head];
        head           <= head + 1'b1;
      end

      // The tail slot is never a live entry here, so the push overrides any wakeup write.
      if (push) begin
        e_valid[tail]  <= 1'b1;
        e_rdy[tail]    <= push_rdy;
        e_data[tail]   <= push_data;
        e_funct3[tail] <= disp_funct3;
        e_uimm[tail]   <= disp_uimm;
        e_imm[tail]    <= disp_imm;
        e_pc[tail]     <= disp_pc;
        e_rob[tail]    <= disp_rob_idx;
        e_rd[tail]     <= disp_rd;
        e_tag[tail]    <= disp_rs1_tag;
        tail           <= tail + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_issue_buffer.sv
// Directed bench for csr_issue_buffer: expected issues are queued at dispatch and
// compared field-by-field whenever the buffer pulses csr_i_valid.
module tb_csr_issue_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_funct3;
  logic [4:0]  disp_uimm;
  logic [31:0] disp_imm;
  logic [31:0] disp_pc;
  logic [3:0]  disp_rob_idx;
  logic [6:0]  disp_rd;
  logic [6:0]  disp_rs1_tag;
  logic        disp_rs1_rdy;
  logic [31:0] disp_rs1_data;
  logic        wb_valid;
  logic [6:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  rob_head_idx;
  logic        flush;
  logic        csr_i_valid;
  logic [2:0]  csr_i_funct3;
  logic [4:0]  csr_i_uimm;
  logic [31:0] csr_i_imm;
  logic [31:0] csr_i_rs1_data;
  logic [31:0] csr_i_pc;
  logic [3:0]  csr_i_rob_idx;
  logic [6:0]  csr_i_rd;

  csr_issue_buffer #(.DEPTH(4), .ROB_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_funct3(disp_funct3), .disp_uimm(disp_uimm), .disp_imm(disp_imm),
    .disp_pc(disp_pc), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_data(disp_rs1_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rob_head_idx(rob_head_idx), .flush(flush),
    .csr_i_valid(csr_i_valid), .csr_i_funct3(csr_i_funct3), .csr_i_uimm(csr_i_uimm),
    .csr_i_imm(csr_i_imm), .csr_i_rs1_data(csr_i_rs1_data), .csr_i_pc(csr_i_pc),
    .csr_i_rob_idx(csr_i_rob_idx), .csr_i_rd(csr_i_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [4:0]  uimm;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic [6:0]  rd;
  } rec_t;

  rec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] rob, input logic [31:0] pc, input logic [31:0] rs1);
    rec_t r;
    r.f3   = pc[6:4];
    r.uimm = pc[6:2];
    r.imm  = 32'h300 + pc;
    r.rs1  = rs1;
    r.pc   = pc;
    r.rob  = rob;
    r.rd   = pc[9:3];
    return r;
  endfunction

  task automatic drive(input logic [3:0] rob, input logic [31:0] pc, input logic rdy,
                       input logic [6:0] tag, input logic [31:0] data);
    disp_valid    = 1'b1;
    disp_funct3   = pc[6:4];
    disp_uimm     = pc[6:2];
    disp_imm      = 32'h300 + pc;
    disp_pc       = pc;
    disp_rob_idx  = rob;
    disp_rd       = pc[9:3];
    disp_rs1_tag  = tag;
    disp_rs1_rdy  = rdy;
    disp_rs1_data = data;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
  endtask

  // Advance one clock and score any issue pulse against the queue head.
  task automatic tick();
    rec_t o, e;
    @(posedge clk);
    #1;
    if (csr_i_valid) begin
      chk("issue_expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        o = {csr_i_funct3, csr_i_uimm, csr_i_imm, csr_i_rs1_data, csr_i_pc, csr_i_rob_idx, csr_i_rd};
        chk("issue_fields", 128'(o), 128'(e));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; disp_valid = 1'b0; disp_funct3 = '0; disp_uimm = '0; disp_imm = '0;
    disp_pc = '0; disp_rob_idx = '0; disp_rd = '0; disp_rs1_tag = '0; disp_rs1_rdy = 1'b0;
    disp_rs1_data = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; rob_head_idx = '0; flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", disp_ready, 0);
    chk("rst_valid", csr_i_valid, 0);
    chk("rst_data", {csr_i_rs1_data, csr_i_pc, csr_i_imm}, 0);
    rst = 1'b0; #1;
    chk("ready_after_rst", disp_ready, 1);

    // Ready op issues one cycle after push
    rob_head_idx = 4'd3;
    drive(4'd3, 32'h100, 1'b1, 7'h0, 32'h55); sb.push_back(mk(4'd3, 32'h100, 32'h55));
    tick(); idle();
    chk("t1_no_early", csr_i_valid, 0);
    tick();
    chk("t1_pulse", csr_i_valid, 1);
    tick();
    chk("t1_single", csr_i_valid, 0);
    chk("t1_hold_pc", csr_i_pc, 32'h100);
    chk("t1_hold_rs1", csr_i_rs1_data, 32'h55);
    chk("t1_empty_ready", disp_ready, 1);

    // Writeback wakeup, then issue one cycle after the wakeup edge
    rob_head_idx = 4'd4;
    drive(4'd4, 32'h200, 1'b0, 7'h12, 32'hDEAD); sb.push_back(mk(4'd4, 32'h200, 32'hABCD));
    tick(); idle();
    tick(); tick();
    chk("t2_wait", csr_i_valid, 0);
    wb_valid = 1'b1; wb_rd = 7'h12; wb_data = 32'hABCD;
    tick(); wb_valid = 1'b0;
    chk("t2_wake_no_issue", csr_i_valid, 0);
    tick();
    chk("t2_pulse", csr_i_valid, 1);
    tick();

    // Bypass capture at dispatch
    rob_head_idx = 4'd5;
    drive(4'd5, 32'h240, 1'b0, 7'h20, 32'h0); sb.push_back(mk(4'd5, 32'h240, 32'h77));
    wb_valid = 1'b1; wb_rd = 7'h20; wb_data = 32'h77;
    tick(); idle(); wb_valid = 1'b0;
    tick();
    chk("t3_pulse", csr_i_valid, 1);
    tick();

    // Head blocks a ready younger op; ready op ignores a matching broadcast
    rob_head_idx = 4'd8;
    drive(4'd7, 32'h280, 1'b0, 7'h30, 32'h0);  sb.push_back(mk(4'd7, 32'h280, 32'h99));
    tick();
    drive(4'd8, 32'h2C0, 1'b1, 7'h30, 32'h11); sb.push_back(mk(4'd8, 32'h2C0, 32'h11));
    tick(); idle();
    tick(); tick();
    chk("t4_no_ooo", csr_i_valid, 0);
    wb_valid = 1'b1; wb_rd = 7'h30; wb_data = 32'h99; rob_head_idx = 4'd7;
    tick(); wb_valid = 1'b0;
    chk("t4_wake_no_issue", csr_i_valid, 0);
    tick();
    chk("t4_head_pulse", csr_i_valid, 1);
    rob_head_idx = 4'd8;
    tick();
    chk("t4_second_pulse", csr_i_valid, 1);
    tick();
    chk("t4_idle", csr_i_valid, 0);

    // Fill to DEPTH with mismatched ROB head, then drain
    rob_head_idx = 4'd15;
    for (int i = 0; i < 4; i++) begin
      chk("t5_accept", disp_ready, 1);
      drive(4'(5 + i), 32'h300 + 32'(16 * i), 1'b1, 7'h0, 32'h1000 + 32'(i));
      sb.push_back(mk(4'(5 + i), 32'h300 + 32'(16 * i), 32'h1000 + 32'(i)));
      tick();
    end
    idle(); #1;
    chk("t5_full", disp_ready, 0);
    rob_head_idx = 4'd5;
    tick();
    chk("t5_first_pulse", csr_i_valid, 1);
    chk("t5_ready_after_pop", disp_ready, 1);
    for (int k = 1; k < 4; k++) begin
      rob_head_idx = 4'(5 + k);
      tick();
      chk("t5_drain", csr_i_valid, 1);
    end
    tick();
    chk("t5_idle", csr_i_valid, 0);

    // Six ops across pointer wrap with simultaneous push/pop
    rob_head_idx = 4'd0;
    for (int i = 0; i < 4; i++) begin
      drive(4'(9 + i), 32'h400 + 32'(16 * i), 1'b1, 7'h0, 32'h2000 + 32'(i));
      sb.push_back(mk(4'(9 + i), 32'h400 + 32'(16 * i), 32'h2000 + 32'(i)));
      tick();
    end
    idle();
    rob_head_idx = 4'd9;
    tick();
    chk("t6_pulse", csr_i_valid, 1);
    for (int k = 1; k < 6; k++) begin
      rob_head_idx = 4'(9 + k);
      if (k <= 2) begin
        drive(4'(12 + k), 32'h400 + 32'(16 * (3 + k)), 1'b1, 7'h0, 32'h2000 + 32'(3 + k));
        sb.push_back(mk(4'(12 + k), 32'h400 + 32'(16 * (3 + k)), 32'h2000 + 32'(3 + k)));
      end else begin
        idle();
      end
      tick();
      chk("t6_pulse", csr_i_valid, 1);
    end
    tick();
    chk("t6_idle", csr_i_valid, 0);
    chk("t6_sb_drained", sb.size(), 0);

    // Flush with an eligible head and a simultaneous push
    rob_head_idx = 4'd0;
    drive(4'd1, 32'h500, 1'b1, 7'h0, 32'h1); tick();
    drive(4'd2, 32'h510, 1'b1, 7'h0, 32'h2); tick();
    rob_head_idx = 4'd1; flush = 1'b1;
    drive(4'd3, 32'h520, 1'b1, 7'h0, 32'h3);
    #1;
    chk("t7_ready_in_flush", disp_ready, 0);
    tick(); flush = 1'b0; idle();
    chk("t7_no_pulse", csr_i_valid, 0);
    #1;
    chk("t7_ready_after", disp_ready, 1);
    tick();
    chk("t7_still_none", csr_i_valid, 0);
    tick();
    chk("t7_still_none2", csr_i_valid, 0);
    rob_head_idx = 4'd15;
    for (int i = 0; i < 4; i++) begin
      chk("t7_accept", disp_ready, 1);
      drive(4'(4 + i), 32'h600 + 32'(16 * i), 1'b1, 7'h0, 32'h3000 + 32'(i));
      tick();
    end
    idle(); #1;
    chk("t7_full_after_4", disp_ready, 0);

    // Reset mid-operation with a now-eligible head
    rob_head_idx = 4'd4; rst = 1'b1;
    tick();
    chk("t8_rst_valid", csr_i_valid, 0);
    chk("t8_rst_data", {csr_i_rs1_data, csr_i_pc}, 0);
    chk("t8_rst_ready", disp_ready, 0);
    rst = 1'b0;
    tick();
    chk("t8_no_pulse", csr_i_valid, 0);
    tick();
    chk("t8_no_pulse2", csr_i_valid, 0);
    chk("t8_ready", disp_ready, 1);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_issue_buffer.md
CSR_ISSUE_BUFFER -- requirements
Module: csr_issue_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered CSR ops (power of two, >=2).
REQ-002 Parameter ROB_LEN, default 16, ROB entries; IW = clog2(ROB_LEN).
REQ-003 Ports, in order:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- disp_valid  in  1  dispatch offers a CSR op.
- disp_ready  out  1  buffer accepts the op.
- disp_funct3  in  3  CSR op.
- disp_uimm  in  5  zimm field.
- disp_imm  in  32  CSR address / MRET encoding.
- disp_pc  in  32  op PC.
- disp_rob_idx  in  IW  ROB slot.
- disp_rd  in  7  physical destination.
- disp_rs1_tag  in  7  physical rs1.
- disp_rs1_rdy  in  1  rs1 value already available.
- disp_rs1_data  in  32  rs1 value when disp_rs1_rdy.
- wb_valid  in  1  writeback broadcast valid.
- wb_rd  in  7  writeback physical tag.
- wb_data  in  32  writeback value.
- rob_head_idx  in  IW  current ROB head.
- flush  in  1  pipeline squash.
- csr_i_valid  out  1  issue pulse to CSR unit.
- csr_i_funct3, csr_i_uimm, csr_i_imm, csr_i_rs1_data, csr_i_pc, csr_i_rob_idx, csr_i_rd  out  3/5/32/32/32/IW/7  issued op fields.

Function
REQ-004 Buffer is an in-order circular FIFO of DEPTH entries with head/tail pointers (wrap at DEPTH) and a count 0..DEPTH.
REQ-005 disp_ready = (count < DEPTH) && !flush; depends on registered count only, not on a same-cycle pop.
REQ-006 Push on disp_valid && disp_ready: entry stores all disp_* fields; rs1 ready bit = disp_rs1_rdy || (wb_valid && wb_rd == disp_rs1_tag); data from wb_data when captured by the bypass and disp_rs1_rdy=0, else disp_rs1_data.
REQ-007 Each cycle, every valid entry with rs1 not ready and rs1_tag == wb_rd while wb_valid sets ready and captures wb_data; already-ready entries ignore the broadcast.
REQ-008 Head is eligible when count>0, head rs1 ready, and head rob_idx == rob_head_idx, with no flush.
REQ-009 Eligible at edge N: head popped at that edge; output register loaded with its fields; csr_i_valid=1 for exactly the cycle after edge N.
REQ-010 At most one pop per cycle; only the head ever issues (no out-of-order issue).
REQ-011 csr_i_valid deasserts the cycle after any pulse unless a new eligible head issues; csr_i_* data fields hold their last value when csr_i_valid=0.
REQ-012 Simultaneous push and pop: both take effect; count unchanged.
REQ-013 Wakeup arriving the same cycle as eligibility evaluation does not make the head eligible that cycle; issue follows one cycle later.
REQ-014 flush=1: all entries invalidated, count=0, pointers=0, csr_i_valid=0 next cycle; flush overrides push, pop and wakeup in that cycle.
REQ-015 Pointer wrap: tail/head increment from DEPTH-1 to 0; ordering preserved across wrap.

Reset
REQ-016 While rst=1 at a clock edge: count=0, head=tail=0, all entries invalid, csr_i_valid=0, all csr_i_* data outputs 0; disp_ready=0 during reset, 1 the cycle after.
REQ-017 Reset mid-operation discards buffered ops and any pending issue; no csr_i_valid pulse follows reset release.

Verification
REQ-018 Push op rob_idx=3, rs1_rdy=1, rs1_data=0x55, rob_head_idx=3 -> csr_i_valid one cycle, csr_i_rs1_data=0x55, csr_i_rob_idx=3, count returns to 0.
REQ-019 Push op rs1_rdy=0, tag=0x12, head matches; two cycles later wb_valid, wb_rd=0x12, wb_data=0xABCD -> csr_i_valid two cycles after broadcast edge, csr_i_rs1_data=0xABCD.
REQ-020 Push 4 ops with rob_head_idx mismatched -> disp_ready=0 at count=4; set rob_head_idx to first op's idx -> first op issues, disp_ready=1 next cycle.
REQ-021 Push 6 ops across wrap, advance rob_head_idx per op -> six issues in dispatch order, pc values matching.
REQ-022 Two buffered ops, head eligible, flush=1 same cycle -> no csr_i_valid pulse, count=0, disp_ready=1 the cycle after flush drops.
